// File: rtl/gba_rom_loader.sv
// Packs the iosys ROM byte stream into 16-bit little-endian words and writes them over a req/ack port.
// Word enters the FIFO on the odd-byte strobe; a full FIFO drops the word and sets overflow.
module gba_rom_loader_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [W-1:0]             next_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_nxt;

  assign rd_nxt   = rd_ptr + 1'b1;
  assign head_dat = mem[rd_ptr];
  assign next_dat = mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
endmodule

module gba_rom_loader #(
  parameter int ADDR_WIDTH = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            rom_loading,
  input  logic [7:0]            rom_do,
  input  logic                  rom_do_valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   rom_size,
  output logic [31:0]           game_code,
  output logic                  overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + 16;
  localparam logic [ADDR_WIDTH:0] HDR_BASE = (ADDR_WIDTH+1)'(8'hAC);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t                state;
  logic [7:0]            low_byte;
  logic                  push_req;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic [EW-1:0]         push_dat;
  logic [EW-1:0]         head_dat;
  logic [EW-1:0]         next_dat;
  logic [CW-1:0]         fifo_cnt;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH:0]   hdr_off;

  assign word_addr = {rom_size[ADDR_WIDTH-1:1], 1'b0};
  assign hdr_off   = rom_size - HDR_BASE;
  assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_pop  = mem_req & mem_ack;
  assign fifo_push = push_req & ~fifo_full;

  // rom_size doubles as the byte counter; bit ADDR_WIDTH set means the ROM space is exhausted.
  always_comb begin
    push_req = 1'b0;
    push_dat = '0;
    if (state == LOAD) begin
      if (rom_loading == 2'd0) begin
        if (rom_size[0]) begin
          push_req = 1'b1;
          push_dat = {word_addr, 8'hFF, low_byte};
        end
      end else if (rom_do_valid && !rom_size[ADDR_WIDTH] && rom_size[0]) begin
        push_req = 1'b1;
        push_dat = {word_addr, rom_do, low_byte};
      end
    end
  end

  gba_rom_loader_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .next_dat (next_dat),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_size  <= '0;
      game_code <= '0;
      overflow  <= 1'b0;
      low_byte  <= '0;
    end else begin
      done <= 1'b0;
      if (push_req && fifo_full) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (rom_loading != 2'd0) begin
            state     <= LOAD;
            busy      <= 1'b1;
            rom_size  <= '0;
            game_code <= '0;
            overflow  <= 1'b0;
            low_byte  <= '0;
          end
        end
        LOAD: begin
          if (rom_loading == 2'd0) begin
            state <= DRAIN;
          end else if (rom_do_valid) begin
            if (rom_size[ADDR_WIDTH]) begin
              overflow <= 1'b1;
            end else begin
              rom_size <= rom_size + (ADDR_WIDTH+1)'(1);
              if (!rom_size[0]) low_byte <= rom_do;
              if (hdr_off < (ADDR_WIDTH+1)'(4)) game_code[{hdr_off[1:0], 3'b000} +: 8] <= rom_do;
            end
          end
        end
        DRAIN: begin
          if (fifo_cnt == '0 && !mem_req) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A word pushed into an empty (or just-emptied) FIFO is forwarded straight to the port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (!mem_req) begin
      if (fifo_cnt != '0) begin
        mem_req               <= 1'b1;
        {mem_addr, mem_wdata} <= head_dat;
      end else if (fifo_push) begin
        mem_req               <= 1'b1;
        {mem_addr, mem_wdata} <= push_dat;
      end
    end else if (mem_ack) begin
      if (fifo_cnt > CW'(1)) begin
        {mem_addr, mem_wdata} <= next_dat;
      end else if (fifo_push) begin
        {mem_addr, mem_wdata} <= push_dat;
      end else begin
        mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: doc/gba_rom_loader.md
# gba_rom_loader

Receives the byte stream that the IO subsystem emits during ROM loading: `rom_loading`, plus `rom_do` strobed by `rom_do_valid`. It packs the bytes little-endian into 16-bit words, buffers them in a small FIFO, and writes them to cartridge memory over a req/ack port. It also reports ROM size, the 4-byte game code from the cartridge header, and an overflow flag. It sits between iosys and the SDRAM arbiter's ROM write port.

## Interface
Parameters:
- `ADDR_WIDTH`, default 25: byte address width of ROM space (32 MB).
- `FIFO_DEPTH`, default 4: word FIFO entries. Must be a power of 2, ≥2.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `rom_loading` in 2: nonzero means a load is in progress; the 0→nonzero edge starts a load and the nonzero→0 edge ends it.
- `rom_do` in 8: ROM byte.
- `rom_do_valid` in 1: one-cycle strobe; `rom_do` is valid this cycle.
- `mem_req` out 1: write request, a level signal.
- `mem_addr` out ADDR_WIDTH: byte address of the word; bit 0 is always 0.
- `mem_wdata` out 16: word data; the even byte is in [7:0].
- `mem_ack` in 1: one-cycle pulse that completes the current request.
- `busy` out 1: high in LOAD and DRAIN.
- `done` out 1: one-cycle pulse when a load has fully committed.
- `rom_size` out ADDR_WIDTH+1: number of bytes accepted in the current or last load.
- `game_code` out 32: header bytes 0xAC..0xAF; byte 0xAC is in [7:0].
- `overflow` out 1: sticky, cleared at load start.

## Operation
- States: IDLE, LOAD, DRAIN.
- IDLE → LOAD:
  - Taken when `rom_loading` != 0 is sampled in IDLE.
  - On entry, clear the byte counter, `rom_size`, `overflow` and `game_code`, and flush any partial word.
- LOAD, on each `rom_do_valid`:
  - Let `n` be the byte counter.
  - If `n` < 2^ADDR_WIDTH, accept the byte and increment `n` and `rom_size`. Otherwise drop the byte and set `overflow`.
  - Even `n`: the byte goes to the low half of the pending word.
  - Odd `n`: the byte completes the word, which is pushed as {byte, low} with address `n`-1.
  - If the FIFO is full at push time, drop the word and set `overflow`. `rom_size` still counts the bytes.
  - If `n` is in 0xAC..0xAF, store the byte into `game_code` at byte lane `n`-0xAC.
- LOAD → DRAIN:
  - Taken when `rom_loading` is sampled 0.
  - If a partial word is pending (odd byte count), push {8'hFF, low} with its address. Apply the same full rule as above.
- DRAIN → IDLE:
  - Taken when the FIFO is empty and `mem_req` is low.
  - `done` pulses for 1 cycle on that transition.
- `rom_do_valid` outside LOAD is ignored.
- `rom_loading` going nonzero again during DRAIN is not acted on until IDLE; IDLE then starts a new load on the next cycle.
- Memory port:
  - The FIFO head drives `mem_addr`/`mem_wdata`, which are registered and stable while `mem_req` is high.
  - On `mem_ack`, pop the head.
  - If the FIFO still holds another entry, `mem_req` stays high and the next cycle presents the next word. Otherwise `mem_req` drops the next cycle.
  - `mem_ack` while `mem_req` is low is ignored.
- A push and a pop in the same cycle are both honoured, and the occupancy count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an explicit count.

## Timing
- Reset: asynchronous assertion and synchronous-to-clk deassertion are both supported. While reset is asserted, all outputs go to 0 and the state is IDLE; an outstanding request is abandoned with no ack expected.
- Reset in the middle of a load discards the FIFO and all partial state.
- Byte to FIFO: the word is in the FIFO at the clock edge where the odd byte is strobed, so `mem_req` can rise on the cycle after the odd-byte strobe.
- Throughput: one word per ack. With a same-cycle ack and back-to-back entries, that is one word per cycle.
- `rom_size` and `game_code` update the cycle after the strobe, and both hold after `done` until the next load start.
- `busy` rises the cycle after `rom_loading` is first sampled nonzero, and falls in the same cycle as `done`.

## Test plan
- Basic load:
  - Stimulus: start a load, send bytes 00 01 02 03, end the load; ack each request after 3 cycles.
  - Required: writes (0x0, 0x0100) then (0x2, 0x0302); `rom_size`=4; `done` pulses once; `overflow`=0.
- Odd length: send 5 bytes ending with 0x44 → the last write is (0x4, 0xFF44) and `rom_size`=5.
- Header capture: 192 bytes with byte[i]=i → `game_code`=0xAFAEADAC.
- Backpressure:
  - Stimulus: hold `mem_ack` low, send 12 bytes (6 words) with FIFO_DEPTH=4, then ack each request.
  - Required: exactly 4 words are written, at addresses 0, 2, 4, 6; `overflow`=1; `rom_size`=12.
- Reset mid-load: assert `resetn`=0 while `mem_req` is high → `mem_req`, `busy` and `rom_size` are 0 immediately; a subsequent fresh load starts at address 0.
- Restart: re-raise `rom_loading` during DRAIN → the first load finishes with `done`, then a second load starts with `rom_size` and `overflow` cleared.
